// File: rtl/tiny_dnn_pkg.sv
// tiny_dnn_pkg: shared bf16 type, max-pool ordering key, pool FSM states and window limit.
package tiny_dnn_pkg;
  typedef logic [15:0] bf16_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} pool_state_t;
  localparam int POOL_MAXWIN = 4;
  // Maps bf16 onto an unsigned key whose order is the numeric order, with -0 below +0.
  function automatic logic [15:0] bf16_key(input bf16_t x);
    return x[15] ? ~x : x ^ 16'h8000;
  endfunction
endpackage

// File: rtl/tiny_dnn_pool_lane.sv
// tiny_dnn_pool_lane: one lane of the row buffer; running max (and argmax with TINY_DNN_POOL_PTR_EN).
module tiny_dnn_pool_lane
  import tiny_dnn_pkg::*;
#(
  parameter int MAXOW = 32
`ifdef TINY_DNN_POOL_PTR_EN
  , parameter int PTRW = 4
`endif
) (
  input  logic            clk,
  input  logic            we,
  input  logic            first,
  input  logic [4:0]      idx,
  input  bf16_t           x,
`ifdef TINY_DNN_POOL_PTR_EN
  input  logic [PTRW-1:0] ptr,
  output logic [PTRW-1:0] mptr,
`endif
  output bf16_t           mx
);
  bf16_t mem [MAXOW];
  logic take;
  // Strictly greater replaces, so ties keep the earliest element of the window.
  assign take = first || (bf16_key(x) > bf16_key(mem[idx]));
  assign mx = take ? x : mem[idx];
  always_ff @(posedge clk) if (we) mem[idx] <= mx;
`ifdef TINY_DNN_POOL_PTR_EN
  logic [PTRW-1:0] pmem [MAXOW];
  assign mptr = take ? ptr : pmem[idx];
  always_ff @(posedge clk) if (we) pmem[idx] <= mptr;
`endif
endmodule

// File: rtl/tiny_dnn_pool_pn.sv
// tiny_dnn_pool_pn: runtime PHxPW max-pool over a row-major lane stream with valid/ready output.
// Define TINY_DNN_POOL_PTR_EN to add per-lane argmax pointers on dst_ptr.
module tiny_dnn_pool_pn
  import tiny_dnn_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW = 16,
  parameter int MAXOW = 32
`ifdef TINY_DNN_POOL_PTR_EN
  , parameter int PTRW = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            ph,
  input  logic [2:0]            pw,
  input  logic [4:0]            ow,
  input  logic [4:0]            oh,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [LANES*DW-1:0]   src_data,
  output logic                  dst_valid,
  input  logic                  dst_ready,
  output logic [LANES*DW-1:0]   dst_data,
`ifdef TINY_DNN_POOL_PTR_EN
  output logic [LANES*PTRW-1:0] dst_ptr,
`endif
  output logic                  dst_last,
  output logic                  busy,
  output logic                  p_fin
);
  localparam int CW = $clog2(POOL_MAXWIN);
  pool_state_t state;
  logic [2:0] ph_q, pw_q;
  logic [4:0] ow_q, oh_q, oc, orow;
  logic [CW-1:0] c, r;
  logic acc, first, c_end, r_end, oc_end, o_end, done, last_in, fin;
  logic [LANES*DW-1:0] mx;
  assign src_ready = (state == RUN) && (!dst_valid || dst_ready);
  assign acc = src_valid && src_ready;
  assign first = (r == '0) && (c == '0);
  assign c_end = {1'b0, c} == pw_q - 3'd1;
  assign r_end = {1'b0, r} == ph_q - 3'd1;
  assign oc_end = oc == ow_q - 5'd1;
  assign o_end = orow == oh_q - 5'd1;
  assign done = r_end && c_end;
  assign last_in = done && oc_end && o_end;
  assign fin = (state == DRAIN) && dst_valid && dst_ready;
  assign busy = state != IDLE;
`ifdef TINY_DNN_POOL_PTR_EN
  logic [LANES*PTRW-1:0] mptr;
  logic [PTRW-1:0] wptr;
  assign wptr = PTRW'(r) * PTRW'(pw_q) + PTRW'(c);
`endif
  for (genvar i = 0; i < LANES; i++) begin : lane_g
    tiny_dnn_pool_lane #(
      .MAXOW(MAXOW)
`ifdef TINY_DNN_POOL_PTR_EN
      , .PTRW(PTRW)
`endif
    ) u_lane (
      .clk(clk),
      .we(acc),
      .first(first),
      .idx(oc),
      .x(src_data[i*DW +: DW]),
`ifdef TINY_DNN_POOL_PTR_EN
      .ptr(wptr),
      .mptr(mptr[i*PTRW +: PTRW]),
`endif
      .mx(mx[i*DW +: DW])
    );
  end
  always_ff @(posedge clk) begin
    if (rst || start) begin
      state <= rst ? IDLE : RUN;
      c <= '0;
      r <= '0;
      oc <= '0;
      orow <= '0;
      dst_valid <= 1'b0;
      dst_last <= 1'b0;
      dst_data <= '0;
      p_fin <= 1'b0;
`ifdef TINY_DNN_POOL_PTR_EN
      dst_ptr <= '0;
`endif
      if (!rst) begin
        ph_q <= ph;
        pw_q <= pw;
        ow_q <= ow;
        oh_q <= oh;
      end
    end else begin
      p_fin <= fin;
      if (fin) state <= IDLE;
      else if (acc && last_in) state <= DRAIN;
      if (acc) begin
        c <= c_end ? '0 : c + 1'b1;
        if (c_end) oc <= oc_end ? 5'd0 : oc + 5'd1;
        if (c_end && oc_end) r <= r_end ? '0 : r + 1'b1;
        if (c_end && oc_end && r_end) orow <= o_end ? 5'd0 : orow + 5'd1;
      end
      // A completing window reloads the single output register even while it is being accepted.
      if (acc && done) begin
        dst_valid <= 1'b1;
        dst_data <= mx;
        dst_last <= last_in;
`ifdef TINY_DNN_POOL_PTR_EN
        dst_ptr <= mptr;
`endif
      end else if (dst_ready) dst_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tiny_dnn_pool_pn.sv
// tb_tiny_dnn_pool_pn: randomized frames checked every cycle against a window-max reference model.
module tb_tiny_dnn_pool_pn;
  typedef struct packed {logic [63:0] d; logic [15:0] p; logic l;} exp_t;
  logic clk = 0, rst = 1, start = 0, src_valid = 0, dst_ready = 0;
  logic [2:0] ph = 1, pw = 1;
  logic [4:0] ow = 1, oh = 1;
  logic [63:0] src_data = '0;
  logic src_ready, dst_valid, dst_last, busy, p_fin;
  logic [63:0] dst_data;
  logic [15:0] dst_ptr;
  exp_t q[$];
  logic [63:0] beats[$];
  int vecs = 0, errs = 0;
  logic [15:0] s1 [8] = '{16'h3F80, 16'h4040, 16'h4000, 16'h0000, 16'h40A0, 16'hC080, 16'h40E0, 16'h40C0};
  logic [15:0] s2 [8] = '{16'h4000, 16'h4000, 16'h8000, 16'h0000, 16'h4000, 16'h4000, 16'hBF80, 16'h8000};

  always #5 clk = ~clk;

  tiny_dnn_pool_pn dut (
    .clk(clk), .rst(rst), .start(start), .ph(ph), .pw(pw), .ow(ow), .oh(oh),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
`ifdef TINY_DNN_POOL_PTR_EN
    .dst_ptr(dst_ptr),
`endif
    .dst_last(dst_last), .busy(busy), .p_fin(p_fin)
  );
`ifndef TINY_DNN_POOL_PTR_EN
  assign dst_ptr = '0;
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    vecs++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Numeric bf16 order by sign and magnitude; -0 sits below +0.
  function automatic bit gt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return !a[15];
    return a[15] ? (a[14:0] < b[14:0]) : (a[14:0] > b[14:0]);
  endfunction

  function automatic logic [15:0] rel();
    int m = $urandom_range(0, 7);
    return m == 0 ? 16'h0000 : m == 1 ? 16'h8000 : m == 2 ? 16'h4000 : 16'($urandom);
  endfunction

  task automatic model(input int h, input int w, input int nc, input int no);
    for (int orw = 0; orw < no; orw++)
      for (int col = 0; col < nc; col++) begin
        exp_t e;
        e = '0;
        e.l = (orw == no - 1) && (col == nc - 1);
        for (int k = 0; k < 4; k++) begin
          logic [15:0] best, v;
          int bp;
          best = '0;
          bp = 0;
          for (int rr = 0; rr < h; rr++)
            for (int cc = 0; cc < w; cc++) begin
              v = beats[((orw * h + rr) * nc + col) * w + cc][k*16 +: 16];
              if ((rr == 0 && cc == 0) || gt(v, best)) begin
                best = v;
                bp = rr * w + cc;
              end
            end
          e.d[k*16 +: 16] = best;
          e.p[k*4 +: 4] = bp[3:0];
        end
        q.push_back(e);
      end
  endtask

  task automatic start_frame(input int h, input int w, input int nc, input int no, input bit rnd);
    if (rnd) begin
      beats.delete();
      for (int i = 0; i < h * w * nc * no; i++) begin
        logic [63:0] b;
        for (int k = 0; k < 4; k++) b[k*16 +: 16] = rel();
        beats.push_back(b);
      end
    end
    @(posedge clk);
    #1 start = 1; src_valid = 0;
    ph = h[2:0]; pw = w[2:0]; ow = nc[4:0]; oh = no[4:0];
    @(posedge clk);
    #1 start = 0;
    model(h, w, nc, no);
  endtask

  task automatic feed(input int n, input bit gaps);
    int i = 0, t = 0;
    while (i < n && t < 5000) begin
      @(posedge clk);
      #1 src_valid = !gaps || ($urandom_range(0, 3) != 0);
      src_data = beats[i];
      @(negedge clk);
      if (src_valid && src_ready) i++;
      t++;
    end
    @(posedge clk);
    #1 src_valid = 0;
    chk("feed_beats", i, n);
  endtask

  task automatic drain(input int mode);
    int held = 0;
    bit got = 0;
    for (int t = 0; t < 5000 && !got; t++) begin
      @(posedge clk);
      #1 dst_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 2) != 0) : (held >= 10);
      @(negedge clk);
      if (dst_valid && !dst_ready) held++;
      if (p_fin) got = 1;
    end
    chk("frame_done", got, 1);
    chk("leftover", q.size(), 0);
  endtask

  task automatic run(input int h, input int w, input int nc, input int no, input int mode);
    start_frame(h, w, nc, no, 1);
    fork
      feed(h * w * nc * no, mode != 0);
      drain(mode);
    join
  endtask

  // Cycle checker: owns the expected busy/p_fin/src_ready view and pops the model queue on accepts.
  initial begin
    bit on = 0, rchk = 0, busy_e = 0, run_e = 0, fin_e = 0, held = 0;
    logic [80:0] hv = '0;
    int taken = 0, total = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (on) begin
        if (rchk) chk("reset_vals", {src_ready, dst_valid, dst_last, busy, p_fin, dst_data, dst_ptr}, '0);
        else begin
          chk("src_ready", src_ready, run_e && (!dst_valid || dst_ready));
          chk("busy", busy, busy_e);
          chk("p_fin", p_fin, fin_e);
          if (held) chk("hold", {dst_valid, dst_last, dst_data, dst_ptr}, {1'b1, hv});
        end
      end
      fin_e = 0;
      held = 0;
      if (rst) begin
        on = 1; rchk = 1; busy_e = 0; run_e = 0;
        q.delete();
      end else if (start) begin
        rchk = 0; busy_e = 1; run_e = 1; taken = 0;
        total = int'(ph) * int'(pw) * int'(ow) * int'(oh);
        q.delete();
      end else begin
        rchk = 0;
        if (src_valid && src_ready && run_e) begin
          taken++;
          if (taken == total) run_e = 0;
        end
        if (dst_valid && dst_ready) begin
          if (q.size() == 0) chk("extra_output", {dst_last, dst_data}, '0);
          else begin
            e = q.pop_front();
            chk("data", dst_data, e.d);
            chk("last", dst_last, e.l);
`ifdef TINY_DNN_POOL_PTR_EN
            chk("ptr", dst_ptr, e.p);
`endif
            if (e.l) begin
              fin_e = 1;
              busy_e = 0;
            end
          end
        end
        if (dst_valid && !dst_ready) begin
          held = 1;
          hv = {dst_last, dst_data, dst_ptr};
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lb;
    repeat (3) @(posedge clk);
    #1 rst = 0; dst_ready = 1;
    // 2x2, two windows: lane0 maxima 5 (ptr 2) and 7 (ptr 2)
    beats.delete();
    for (int i = 0; i < 8; i++) begin
      logic [63:0] b;
      b = {$urandom, $urandom};
      b[15:0] = s1[i];
      beats.push_back(b);
    end
    start_frame(2, 2, 2, 1, 0);
    chk("pin_w0", {q[0].d[15:0], q[0].p[3:0]}, {16'h40A0, 4'd2});
    chk("pin_w1", {q[1].d[15:0], q[1].p[3:0]}, {16'h40E0, 4'd2});
    chk("pin_last", {q[0].l, q[1].l}, 2'b01);
    fork feed(8, 0); drain(0); join
    // ties and signed zero
    beats.delete();
    for (int i = 0; i < 8; i++) begin
      logic [63:0] b;
      b = {$urandom, $urandom};
      b[15:0] = s2[i];
      beats.push_back(b);
    end
    start_frame(2, 2, 2, 1, 0);
    chk("pin_tie", {q[0].d[15:0], q[0].p[3:0]}, {16'h4000, 4'd0});
    chk("pin_zero", {q[1].d[15:0], q[1].p[3:0]}, {16'h0000, 4'd1});
    fork feed(8, 1); drain(1); join
    // 3x1 window, 24 beats -> 8 outputs, last only on the 8th
    start_frame(3, 1, 4, 2, 1);
    chk("pin_8out", q.size(), 8);
    for (int i = 0; i < 8; i++) lb[i] = q[i].l;
    chk("pin_last8", lb, 8'h80);
    fork feed(24, 1); drain(1); join
    // backpressure at the first output
    run(2, 2, 2, 2, 2);
    run(1, 1, 5, 3, 1);
    run(4, 4, 3, 2, 1);
    repeat (4) run($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 1));
    // reset mid-frame
    start_frame(2, 2, 3, 2, 1);
    feed(7, 0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    run(2, 1, 2, 1, 0);
    // start mid-frame, then a fresh 1x1 pass-through frame
    start_frame(2, 3, 2, 2, 1);
    feed(5, 0);
    run(1, 1, 4, 1, 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tiny_dnn_pool_pn.md
# tiny_dnn_pool_pn

Parametrised max-pool engine; successor to the fixed 2x2, 4-lane pool unit. It pools a row-major activation stream of `LANES` channel lanes over a runtime-selected PH x PW window, with stride equal to the window. It sits beside `src_buf` on the src stream and feeds `dst_buf` through a valid/ready output. It adds backpressure, runtime window size, frame-done signalling and an optional argmax pointer for backprop.

## Interface
- `LANES`, default 4: channel lanes per beat.
- `DW`, default 16: element width (bf16: sign, exp8, man7).
- `MAXOW`, default 32: max output columns; sets row-buffer depth.
- `PTRW`, default 4: pointer width per lane; must cover `PH*PW-1`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; latches config and clears counters.
- `ph`, `pw` in 3 each: window height and width, 1..4.
- `ow` in 5: output columns, 1..`MAXOW`. Input row width is `ow*pw`.
- `oh` in 5: output rows, 1..31.
- `src_valid`, `src_ready` in/out 1: input handshake.
- `src_data` in `LANES*DW`: lane *k* is at bits `[k*DW +: DW]`.
- `dst_valid`, `dst_ready` out/in 1: output handshake.
- `dst_data` out `LANES*DW`: pooled maxima.
- `dst_ptr` out `LANES*PTRW`: argmax index per lane. Present only with the macro.
- `dst_last` out 1: marks the final output beat of a frame.
- `busy` out 1: high from `start` until the last output is accepted.
- `p_fin` out 1: one-cycle pulse when the last output is accepted.

## Operation
- **States.** IDLE, RUN, DRAIN.
  - `start` in any state goes to RUN.
  - RUN goes to DRAIN when the last input beat of the frame is taken.
  - DRAIN goes to IDLE when the final `dst_valid && dst_ready`. `p_fin` pulses on that cycle.
- **Counters.** Per accepted beat (`src_valid && src_ready`), advance c (0..pw-1), then oc (0..ow-1), then r (0..ph-1), then orow (0..oh-1).
- **Ordering.** Elements compare by key: if sign=1, key = ~x, else key = x ^ 0x8000 (unsigned compare). No special NaN handling. -0 < +0.
- **Row buffer.** Holds `MAXOW` x `LANES` running max and pointer. On the first window element (r==0 && c==0), load without compare. Otherwise, replace only if the key is strictly greater, so ties keep the earliest element. The pointer is r*pw+c.
- **Output.** The window completes at r==ph-1, c==pw-1. The merged result goes to the output register, with `dst_last` set when orow==oh-1 and oc==ow-1.
- **ph=pw=1.** This is a pass-through; pointer is 0.
- **IDLE.** `src_ready`=0 and beats are ignored.
- **`start` mid-frame.** Discards all state. No `p_fin` is raised for the aborted frame.

## Timing
- **Reset values.** `src_ready`=0, `dst_valid`=0, `dst_last`=0, `busy`=0, `p_fin`=0. `dst_data` and `dst_ptr` are 0. State is IDLE.
- **Latency.** `dst_valid` rises on the clock after the completing beat is accepted (1 cycle).
- **Input ready.** `src_ready` = RUN && (!`dst_valid` || `dst_ready`). There is one output register and no skid; a window completing while the output is held stalls input.
- **Simultaneous accept and complete.** Output accepted in the same cycle a new window completes: the register reloads and `dst_valid` stays high.
- **Output hold.** `dst_data`, `dst_ptr` and `dst_last` hold stable while `dst_valid && !dst_ready`.
- **Start latch.** `start` has priority over `rst`=0 traffic. Config is latched on the `start` cycle. `src_ready` may be high the next cycle.

## Configuration
- **Macro `TINY_DNN_POOL_PTR_EN`.**
  - Defined: pointer storage, the compare-select path and the `dst_ptr` port exist.
  - Undefined: no pointer storage and no `dst_ptr` port; max values are unchanged.

## Structure
- **Shared package `tiny_dnn_pkg`.**
  - `bf16_t` typedef.
  - `bf16_key()` ordering function.
  - Pool state enum {IDLE, RUN, DRAIN}.
  - `POOL_MAXWIN`=4 constant.
- **Sub-module `tiny_dnn_pool_lane`.** One per lane, instantiated via generate. It holds the row-buffer slice and the compare/replace logic. The top keeps the counters, FSM and handshake.

## Test plan
- **2x2, ow=2, oh=1, lane0.** Rows [1,3,2,0]/[5,-4,7,6] -> outputs 5 (ptr 2), then 7 (ptr 2). `dst_last` on the second; `p_fin` one cycle after its accept.
- **Ties and signed zero.** 2x2 window all 2.0 -> ptr 0. Window [-0,+0,-1,-0] -> +0, ptr 1.
- **3x1 window (ph=3, pw=1), ow=4, oh=2.** 24 beats -> 8 outputs. Random data is checked against a model, with `dst_last` only on the 8th.
- **Backpressure.** `dst_ready`=0 for 10 cycles at the first output -> `src_ready`=0 after the next completing beat, `dst_data` stable, no loss or duplication.
- **Reset/restart.** `rst` mid-frame -> all outputs at reset values next cycle. `start` mid-frame -> a fresh 1x1 frame passes data through, ptr 0, with no `p_fin` for the aborted frame.
- **Macro off.** Build without `TINY_DNN_POOL_PTR_EN`, rerun the first scenario -> identical `dst_data`, `dst_last` and `p_fin`.
